// File: rtl/mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_ctrl
// Purpose : Requester-side controller for a registered-input single-port RAM:
//           valid/ready request channel, valid/ready read response channel,
//           and a bulk fill engine that writes INIT_VALUE to every location.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_ctrl #(
   parameter int              AW         = 8,
   parameter int              DW         = 16,
   parameter logic [DW-1:0]   INIT_VALUE = '0
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   input  logic          init_start,
   output logic          init_busy,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_din,
   output logic          mem_wen,
   input  logic [DW-1:0] mem_dout
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD_A = 3'd1;
   localparam logic [2:0] S_RD_B = 3'd2;
   localparam logic [2:0] S_RSP  = 3'd3;
   localparam logic [2:0] S_INIT = 3'd4;

   // One past the last fill address; the extra counter bit avoids wrap ambiguity.
   localparam logic [AW:0] C_FILL_DONE = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] C_CNT_ONE   = {{AW{1'b0}}, 1'b1};

   logic [2:0]    state_q,  state_d;
   logic [AW:0]   cnt_q,    cnt_d;
   logic [AW-1:0] addr_q,   addr_d;
   logic [DW-1:0] din_q,    din_d;
   logic          wen_q,    wen_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q,  rdata_d;
   logic          busy_q,   busy_d;

   logic w_req_fire;

   assign req_ready  = (state_q == S_IDLE) && !init_start && reset_n;
   assign w_req_fire = req_valid && req_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      din_d    = din_q;
      wen_d    = 1'b0;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      busy_d   = busy_q;

      case (state_q)
         S_IDLE: begin
            if (init_start) begin
               state_d = S_INIT;
               busy_d  = 1'b1;
               cnt_d   = '0;
            end else if (w_req_fire) begin
               addr_d = req_addr;
               if (req_write) begin
                  din_d = req_wdata;
                  wen_d = 1'b1;
               end else begin
                  state_d = S_RD_A;
               end
            end
         end
         // The RAM registers the address on this edge; its output is valid after it.
         S_RD_A: state_d = S_RD_B;
         S_RD_B: begin
            rdata_d  = mem_dout;
            rvalid_d = 1'b1;
            state_d  = S_RSP;
         end
         S_RSP: begin
            if (rsp_ready) begin
               rvalid_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         S_INIT: begin
            if (cnt_q == C_FILL_DONE) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               addr_d = cnt_q[AW-1:0];
               din_d  = INIT_VALUE;
               wen_d  = 1'b1;
               cnt_d  = cnt_q + C_CNT_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         din_q    <= '0;
         wen_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         wen_q    <= wen_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
      end
   end

   assign mem_address = addr_q;
   assign mem_din     = din_q;
   assign mem_wen     = wen_q;
   assign rsp_valid   = rvalid_q;
   assign rsp_data    = rdata_q;
   assign init_busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_ctrl
// Purpose : Self-checking bench for mem_port_ctrl with a 256x16 registered RAM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_ctrl;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam logic [DW-1:0] C_INIT = 16'hA5A5;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic          init_start = 1'b0;
   logic          init_busy;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_din;
   logic          mem_wen;
   logic [DW-1:0] mem_dout;

   always #5 clock = ~clock;

   mem_port_ctrl #(.AW(AW), .DW(DW), .INIT_VALUE(C_INIT)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .init_start(init_start), .init_busy(init_busy),
      .mem_address(mem_address), .mem_din(mem_din), .mem_wen(mem_wen),
      .mem_dout(mem_dout)
   );

   // RAM with registered inputs and no reset
   logic [DW-1:0] mem_arr [0:255];
   logic [AW-1:0] mem_addr_r;
   always @(posedge clock) begin
      mem_addr_r <= mem_address;
      if (mem_wen) mem_arr[mem_address] <= mem_din;
   end
   assign mem_dout = mem_arr[mem_addr_r];

   // Reference contents: what a correct controller must have stored
   logic [DW-1:0] ref_mem [0:255];
   bit            known   [0:255];

   int total = 0;
   int bad   = 0;
   int last_waits = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int waits;
      waits = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      #1;
      while (!req_ready && waits < 600) begin
         @(negedge clock); #1; waits++;
      end
      if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
      @(posedge clock);
      @(negedge clock);
      if (w) begin ref_mem[a] = d; known[a] = 1'b1; end
      last_waits = waits;
   endtask

   task automatic get_rsp(input logic [DW-1:0] exp, input int stall, input string nm);
      int lat;
      lat = 0;
      req_valid = 1'b0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clock); lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'd2);
      for (int s = 0; s < stall; s++) begin
         chk({nm, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({nm, "_hold_data"}, 32'(rsp_data), 32'(exp));
         chk({nm, "_hold_noready"}, 32'(req_ready), 32'd0);
         @(negedge clock);
      end
      chk({nm, "_data"}, 32'(rsp_data), 32'(exp));
      rsp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      rsp_ready = 1'b0;
      chk({nm, "_valid_drop"}, 32'(rsp_valid), 32'd0);
   endtask

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] e;
      int n, nw, rdy, seen;

      tbl[0] = '{w:1'b1, a:8'h12, d:16'hBEEF, exp:16'h0000};
      tbl[1] = '{w:1'b0, a:8'h12, d:16'h0000, exp:16'hBEEF};
      tbl[2] = '{w:1'b1, a:8'h00, d:16'h1111, exp:16'h0000};
      tbl[3] = '{w:1'b1, a:8'h01, d:16'h2222, exp:16'h0000};
      tbl[4] = '{w:1'b1, a:8'h02, d:16'h3333, exp:16'h0000};
      tbl[5] = '{w:1'b1, a:8'h03, d:16'h4444, exp:16'h0000};
      tbl[6] = '{w:1'b0, a:8'h00, d:16'h0000, exp:16'h1111};
      tbl[7] = '{w:1'b0, a:8'h01, d:16'h0000, exp:16'h2222};
      tbl[8] = '{w:1'b0, a:8'h02, d:16'h0000, exp:16'h3333};
      tbl[9] = '{w:1'b0, a:8'h03, d:16'h0000, exp:16'h4444};

      // reset state
      repeat (2) @(negedge clock);
      chk("rst_mem_address", 32'(mem_address), 32'd0);
      chk("rst_mem_din", 32'(mem_din), 32'd0);
      chk("rst_mem_wen", 32'(mem_wen), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_init_busy", 32'(init_busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("idle_req_ready", 32'(req_ready), 32'd1);

      // table-driven basic traffic
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].w, tbl[i].a, tbl[i].d);
         if (tbl[i].w) begin
            chk("tbl_wr_wen", 32'(mem_wen), 32'd1);
            chk("tbl_wr_addr", 32'(mem_address), 32'(tbl[i].a));
            chk("tbl_wr_din", 32'(mem_din), 32'(tbl[i].d));
            chk("tbl_wr_b2b", 32'(last_waits), 32'd0);
         end else begin
            chk("tbl_rd_wen_low", 32'(mem_wen), 32'd0);
            get_rsp(tbl[i].exp, 0, "tbl_rd");
         end
      end

      // response held under back-pressure
      send(1'b1, 8'h05, 16'h0505);
      send(1'b0, 8'h05, 16'h0000);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h06;
      get_rsp(16'h0505, 5, "hold");
      #1 chk("hold_back_idle", 32'(req_ready), 32'd1);

      // reset while in RD_B
      send(1'b0, 8'h12, 16'h0000);
      req_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("rdb_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rdb_rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rdb_rst_mem_address", 32'(mem_address), 32'd0);
      chk("rdb_rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clock);
         if (rsp_valid) seen++;
      end
      chk("rdb_no_rsp", 32'(seen), 32'd0);
      send(1'b0, 8'h12, 16'h0000);
      get_rsp(16'hBEEF, 0, "rdb_reread");

      // randomized traffic against the reference contents
      for (int i = 0; i < 150; i++) begin
         a = 8'($urandom_range(0, 15));
         w = ($urandom_range(0, 1) == 1) || !known[a];
         d = 16'($urandom);
         if (w) begin
            send(1'b1, a, d);
            chk("rnd_wr_wen", 32'(mem_wen), 32'd1);
         end else begin
            e = ref_mem[a];
            send(1'b0, a, 16'h0000);
            get_rsp(e, $urandom_range(0, 3), "rnd_rd");
         end
      end
      req_valid = 1'b0;

      // init fill with a competing request held
      @(negedge clock);
      init_start = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_wdata = 16'h1357;
      #1 chk("init_blocks_req", 32'(req_ready), 32'd0);
      @(posedge clock);
      @(negedge clock);
      init_start = 1'b0;
      n = 0; nw = 0; rdy = 0;
      #1;
      while (init_busy && n < 400) begin
         n++;
         if (mem_wen) nw++;
         if (req_ready) rdy++;
         @(negedge clock); #1;
      end
      chk("init_busy_cycles", 32'(n), 32'd257);
      chk("init_wen_cycles", 32'(nw), 32'd256);
      chk("init_no_ready", 32'(rdy), 32'd0);
      chk("init_end_ready", 32'(req_ready), 32'd1);
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      chk("held_wr_wen", 32'(mem_wen), 32'd1);
      chk("held_wr_addr", 32'(mem_address), 32'h40);
      for (int k = 0; k < 256; k++) begin ref_mem[k] = C_INIT; known[k] = 1'b1; end
      ref_mem[8'h40] = 16'h1357;
      send(1'b0, 8'h00, 16'h0); get_rsp(ref_mem[8'h00], 0, "init_rd00");
      send(1'b0, 8'h7F, 16'h0); get_rsp(ref_mem[8'h7F], 0, "init_rd7f");
      send(1'b0, 8'hFF, 16'h0); get_rsp(ref_mem[8'hFF], 0, "init_rdff");
      send(1'b0, 8'h40, 16'h0); get_rsp(ref_mem[8'h40], 1, "init_rd40");

      // abort a fill with reset once address 0x63 has been written
      send(1'b1, 8'h63, 16'h0063);
      send(1'b1, 8'hC8, 16'hC8C8);
      req_valid = 1'b0;
      @(negedge clock);
      init_start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      init_start = 1'b0;
      n = 0;
      while (!(mem_wen && mem_address == 8'h64) && n < 400) begin
         @(negedge clock); n++;
      end
      chk("abort_reached", 32'(n < 400), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", 32'(init_busy), 32'd0);
      chk("abort_wen", 32'(mem_wen), 32'd0);
      chk("abort_addr", 32'(mem_address), 32'd0);
      chk("abort_din", 32'(mem_din), 32'd0);
      chk("abort_rsp_data", 32'(rsp_data), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      for (int k = 0; k <= 8'h63; k++) ref_mem[k] = C_INIT;
      send(1'b0, 8'h63, 16'h0); get_rsp(ref_mem[8'h63], 0, "abort_rd63");
      send(1'b0, 8'hC8, 16'h0); get_rsp(ref_mem[8'hC8], 0, "abort_rdc8");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
